// File: rtl/dcache_load_lookup_s2.sv
// dcache load pipe, lookup stage s2.
// Compares the TLB physical tag against every way read out of the tag array in s1,
// then produces a registered hit pulse, a registered replay pulse, or parks the miss
// in a one-entry buffer that is offered to the MSHR until it is accepted.
module dcache_load_lookup_s2 #(
  parameter int WAY_NUM = 4,
  parameter int PADDR_W = 39,
  parameter int TAG_LOW = 12,
  parameter int TAG_W   = 27,
  parameter int ROBID_W = 7,
  parameter int PERF_W  = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROBID_W-1:0]           in_robid,
  input  logic                         tlb_valid,
  input  logic                         tlb_hit,
  input  logic [PADDR_W-1:0]           tlb_paddr,
  input  logic [WAY_NUM*(TAG_W+1)-1:0] tagarray_rd_data,
  output logic                         hit_valid,
  output logic [WAY_NUM-1:0]           hit_way,
  output logic [PADDR_W-1:0]           hit_paddr,
  output logic [ROBID_W-1:0]           hit_robid,
  output logic                         multihit,
  output logic                         replay_valid,
  output logic [ROBID_W-1:0]           replay_robid,
  output logic                         mshr_allocate_valid,
  input  logic                         mshr_allocate_ready,
  output logic [PADDR_W-1:0]           mshr_allocate_paddr,
  output logic [ROBID_W-1:0]           mshr_allocate_robid,
  output logic [PERF_W-1:0]            perf_hit_cnt,
  output logic [PERF_W-1:0]            perf_miss_cnt
);

  localparam int ENT_W      = TAG_W + 1;
  localparam int LINE_OFF_W = 6;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_MSHR = 1'b1
  } state_t;

  // Isolate the lowest set bit: the hit way reported when several ways match.
  function automatic logic [WAY_NUM-1:0] lowest_one(input logic [WAY_NUM-1:0] v);
    logic [WAY_NUM-1:0] neg;
    neg = ~v + {{(WAY_NUM-1){1'b0}}, 1'b1};
    return v & neg;
  endfunction

  // True when more than one bit is set (clearing the lowest bit leaves something).
  function automatic logic more_than_one(input logic [WAY_NUM-1:0] v);
    logic [WAY_NUM-1:0] dec;
    dec = v - {{(WAY_NUM-1){1'b0}}, 1'b1};
    return |(v & dec);
  endfunction

  state_t              state_q;
  state_t              state_d;

  logic                fire_p0;
  logic                lookup_ok_p0;
  logic [TAG_W-1:0]    req_tag_p0;
  logic [WAY_NUM-1:0]  match_p0;
  logic                any_match_p0;
  logic                hit_p0;
  logic                miss_p0;
  logic                replay_p0;
  logic [PADDR_W-1:0]  line_paddr_p0;
  logic                mshr_fire;

  logic                hit_vld_p1;
  logic [WAY_NUM-1:0]  hit_way_p1;
  logic                multihit_p1;
  logic [PADDR_W-1:0]  hit_paddr_p1;
  logic [ROBID_W-1:0]  hit_robid_p1;
  logic                replay_vld_p1;
  logic [ROBID_W-1:0]  replay_robid_p1;
  logic [PADDR_W-1:0]  park_paddr_p1;
  logic [ROBID_W-1:0]  park_robid_p1;
  logic [PERF_W-1:0]   hit_cnt_q;
  logic [PERF_W-1:0]   miss_cnt_q;

  // ---- p0: request acceptance and combinational tag compare ----
  assign fire_p0       = in_valid & in_ready & ~flush;
  assign lookup_ok_p0  = tlb_valid & tlb_hit;
  assign req_tag_p0    = tlb_paddr[TAG_LOW +: TAG_W];
  assign line_paddr_p0 = {tlb_paddr[PADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};

  for (genvar w = 0; w < WAY_NUM; w++) begin : g_way_cmp
    logic [ENT_W-1:0] entry;
    assign entry       = tagarray_rd_data[w*ENT_W +: ENT_W];
    assign match_p0[w] = lookup_ok_p0 & entry[TAG_W] & (entry[TAG_W-1:0] == req_tag_p0);
  end

  assign any_match_p0 = |match_p0;
  assign hit_p0       = fire_p0 & lookup_ok_p0 & any_match_p0;
  assign miss_p0      = fire_p0 & lookup_ok_p0 & ~any_match_p0;
  assign replay_p0    = fire_p0 & ~lookup_ok_p0;
  assign mshr_fire    = mshr_allocate_valid & mshr_allocate_ready;

  // Parking state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: park on a miss, release on MSHR acceptance or flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (miss_p0) state_d = WAIT_MSHR;
      WAIT_MSHR: if (flush || mshr_fire) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State-decoded handshake outputs; s1 is stalled while a miss is parked.
  always_comb begin
    in_ready            = 1'b0;
    mshr_allocate_valid = 1'b0;
    case (state_q)
      IDLE:      in_ready = 1'b1;
      WAIT_MSHR: mshr_allocate_valid = 1'b1;
      default:   in_ready = 1'b0;
    endcase
  end

  // ---- p1: registered result pulses ----
  // Hit / replay pulses last exactly one cycle; hit_way and multihit are only non-zero with the hit pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_vld_p1    <= 1'b0;
      hit_way_p1    <= '0;
      multihit_p1   <= 1'b0;
      replay_vld_p1 <= 1'b0;
    end else begin
      hit_vld_p1    <= hit_p0;
      hit_way_p1    <= hit_p0 ? lowest_one(match_p0) : '0;
      multihit_p1   <= hit_p0 & more_than_one(match_p0);
      replay_vld_p1 <= replay_p0;
    end
  end

  // Request info captured alongside each outcome and held until the next one of the same kind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_paddr_p1    <= '0;
      hit_robid_p1    <= '0;
      replay_robid_p1 <= '0;
      park_paddr_p1   <= '0;
      park_robid_p1   <= '0;
    end else begin
      if (hit_p0) begin
        hit_paddr_p1 <= tlb_paddr;
        hit_robid_p1 <= in_robid;
      end
      if (replay_p0) begin
        replay_robid_p1 <= in_robid;
      end
      if (miss_p0) begin
        park_paddr_p1 <= line_paddr_p0;
        park_robid_p1 <= in_robid;
      end
    end
  end

  // Wrapping perf counters; a flush does not clear them and a handshake coincident with flush still counts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_p0) begin
        hit_cnt_q <= hit_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end
      if (mshr_fire) begin
        miss_cnt_q <= miss_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign hit_valid           = hit_vld_p1;
  assign hit_way             = hit_way_p1;
  assign multihit            = multihit_p1;
  assign hit_paddr           = hit_paddr_p1;
  assign hit_robid           = hit_robid_p1;
  assign replay_valid        = replay_vld_p1;
  assign replay_robid        = replay_robid_p1;
  assign mshr_allocate_paddr = park_paddr_p1;
  assign mshr_allocate_robid = park_robid_p1;
  assign perf_hit_cnt        = hit_cnt_q;
  assign perf_miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_dcache_load_lookup_s2.sv
// Testbench for dcache_load_lookup_s2: scoreboard of expected outcomes, one task per scenario.
`timescale 1ns/1ps
module tb_dcache_load_lookup_s2;

  localparam int WAY_NUM = 4;
  localparam int PADDR_W = 39;
  localparam int TAG_LOW = 12;
  localparam int TAG_W   = 27;
  localparam int ROBID_W = 7;
  localparam int PERF_W  = 16;
  localparam int ENT_W   = TAG_W + 1;

  localparam int K_HIT    = 0;
  localparam int K_REPLAY = 1;
  localparam int K_MISS   = 2;

  logic                         clock;
  logic                         reset_n;
  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [ROBID_W-1:0]           in_robid;
  logic                         tlb_valid;
  logic                         tlb_hit;
  logic [PADDR_W-1:0]           tlb_paddr;
  logic [WAY_NUM*ENT_W-1:0]     tagarray_rd_data;
  logic                         hit_valid;
  logic [WAY_NUM-1:0]           hit_way;
  logic [PADDR_W-1:0]           hit_paddr;
  logic [ROBID_W-1:0]           hit_robid;
  logic                         multihit;
  logic                         replay_valid;
  logic [ROBID_W-1:0]           replay_robid;
  logic                         mshr_allocate_valid;
  logic                         mshr_allocate_ready;
  logic [PADDR_W-1:0]           mshr_allocate_paddr;
  logic [ROBID_W-1:0]           mshr_allocate_robid;
  logic [PERF_W-1:0]            perf_hit_cnt;
  logic [PERF_W-1:0]            perf_miss_cnt;

  typedef struct {
    int                 kind;
    logic [WAY_NUM-1:0] way;
    logic               mh;
    logic [PADDR_W-1:0] paddr;
    logic [ROBID_W-1:0] robid;
  } exp_t;

  exp_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;
  logic [PERF_W-1:0] exp_hit_cnt;
  logic [PERF_W-1:0] exp_miss_cnt;

  dcache_load_lookup_s2 #(
    .WAY_NUM(WAY_NUM), .PADDR_W(PADDR_W), .TAG_LOW(TAG_LOW),
    .TAG_W(TAG_W), .ROBID_W(ROBID_W), .PERF_W(PERF_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_robid(in_robid),
    .tlb_valid(tlb_valid), .tlb_hit(tlb_hit), .tlb_paddr(tlb_paddr),
    .tagarray_rd_data(tagarray_rd_data),
    .hit_valid(hit_valid), .hit_way(hit_way), .hit_paddr(hit_paddr), .hit_robid(hit_robid),
    .multihit(multihit), .replay_valid(replay_valid), .replay_robid(replay_robid),
    .mshr_allocate_valid(mshr_allocate_valid), .mshr_allocate_ready(mshr_allocate_ready),
    .mshr_allocate_paddr(mshr_allocate_paddr), .mshr_allocate_robid(mshr_allocate_robid),
    .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [ENT_W-1:0] ent(input logic v, input logic [TAG_W-1:0] t);
    return {v, t};
  endfunction

  function automatic exp_t mk_exp(input int kind, input logic [WAY_NUM-1:0] way, input logic mh,
                                  input logic [PADDR_W-1:0] pa, input logic [ROBID_W-1:0] rid);
    exp_t e;
    e.kind = kind; e.way = way; e.mh = mh; e.paddr = pa; e.robid = rid;
    return e;
  endfunction

  task automatic set_req(input logic [ROBID_W-1:0] rid, input logic tv, input logic th,
                         input logic [PADDR_W-1:0] pa, input logic [ENT_W-1:0] e0, input logic [ENT_W-1:0] e1,
                         input logic [ENT_W-1:0] e2, input logic [ENT_W-1:0] e3);
    in_valid = 1'b1; in_robid = rid; tlb_valid = tv; tlb_hit = th; tlb_paddr = pa;
    tagarray_rd_data = {e3, e2, e1, e0};
  endtask

  task automatic clr_req();
    in_valid = 1'b0; tlb_valid = 1'b0; tlb_hit = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; mshr_allocate_ready = 1'b0; clr_req();
    in_robid = '0; tlb_paddr = '0; tagarray_rd_data = '0;
    #1;
    checks++; if ({hit_valid, replay_valid, mshr_allocate_valid, multihit} !== 4'b0000) begin errors++; $display("FAIL reset_valids: got %b required 0000", {hit_valid, replay_valid, mshr_allocate_valid, multihit}); end
    checks++; if (hit_way !== '0) begin errors++; $display("FAIL reset_hit_way: got %b required 0", hit_way); end
    checks++; if ({perf_hit_cnt, perf_miss_cnt} !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d required 0/0", perf_hit_cnt, perf_miss_cnt); end
    checks++; if ({hit_paddr, hit_robid, replay_robid, mshr_allocate_paddr, mshr_allocate_robid} !== '0) begin errors++; $display("FAIL reset_data: got %h/%h/%h/%h/%h required all 0", hit_paddr, hit_robid, replay_robid, mshr_allocate_paddr, mshr_allocate_robid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    checks++; if ({hit_valid, replay_valid, mshr_allocate_valid} !== 3'b000) begin errors++; $display("FAIL post_reset_idle: got %b required 000", {hit_valid, replay_valid, mshr_allocate_valid}); end
    exp_hit_cnt = '0; exp_miss_cnt = '0;
  endtask

  task automatic test_hit();
    logic [TAG_W-1:0]   t;
    logic [PADDR_W-1:0] pa;
    exp_t               e;
    t = 27'h0123456; pa = {t, 12'habc};
    @(negedge clock);
    set_req(7'h05, 1'b1, 1'b1, pa, ent(1'b1, t ^ 27'h1), ent(1'b1, t ^ 27'h100), ent(1'b1, t), ent(1'b0, t));
    exp_q.push_back(mk_exp(K_HIT, 4'b0100, 1'b0, pa, 7'h05)); exp_hit_cnt++;
    @(negedge clock); clr_req();
    checks++; if (hit_valid !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %b required 1", hit_valid); end
    e = exp_q.pop_front();
    checks++; if (hit_way !== e.way) begin errors++; $display("FAIL hit_way: got %b required %b", hit_way, e.way); end
    checks++; if (multihit !== e.mh) begin errors++; $display("FAIL hit_multihit: got %b required %b", multihit, e.mh); end
    checks++; if ({hit_paddr, hit_robid} !== {e.paddr, e.robid}) begin errors++; $display("FAIL hit_info: got %h/%h required %h/%h", hit_paddr, hit_robid, e.paddr, e.robid); end
    checks++; if (perf_hit_cnt !== exp_hit_cnt) begin errors++; $display("FAIL hit_cnt: got %0d required %0d", perf_hit_cnt, exp_hit_cnt); end
    checks++; if ({replay_valid, mshr_allocate_valid} !== 2'b00) begin errors++; $display("FAIL hit_exclusive: got %b required 00", {replay_valid, mshr_allocate_valid}); end
    @(negedge clock);
    checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL hit_pulse_width: got %b required 0", hit_valid); end
  endtask

  task automatic test_multihit();
    logic [TAG_W-1:0]   t;
    logic [PADDR_W-1:0] pa;
    exp_t               e;
    t = 27'h5a5a5a5; pa = {t, 12'h040};
    @(negedge clock);
    set_req(7'h0c, 1'b1, 1'b1, pa, ent(1'b1, t ^ 27'h3), ent(1'b1, t), ent(1'b0, t), ent(1'b1, t));
    exp_q.push_back(mk_exp(K_HIT, 4'b0010, 1'b1, pa, 7'h0c)); exp_hit_cnt++;
    @(negedge clock); clr_req();
    checks++; if (hit_valid !== 1'b1) begin errors++; $display("FAIL mh_pulse: got %b required 1", hit_valid); end
    e = exp_q.pop_front();
    checks++; if ({hit_way, multihit} !== {e.way, e.mh}) begin errors++; $display("FAIL mh_way_flag: got %b/%b required %b/%b", hit_way, multihit, e.way, e.mh); end
    checks++; if (perf_hit_cnt !== exp_hit_cnt) begin errors++; $display("FAIL mh_cnt: got %0d required %0d", perf_hit_cnt, exp_hit_cnt); end
    @(negedge clock);
    checks++; if ({hit_valid, multihit} !== 2'b00) begin errors++; $display("FAIL mh_pulse_width: got %b required 00", {hit_valid, multihit}); end
  endtask

  task automatic test_miss();
    logic [PADDR_W-1:0] pa;
    logic [TAG_W-1:0]   t;
    logic [TAG_W-1:0]   th;
    exp_t               e;
    pa = 39'h123456789; t = pa[TAG_LOW +: TAG_W]; th = 27'h0000777;
    @(negedge clock);
    set_req(7'h11, 1'b1, 1'b1, pa, ent(1'b0, t), ent(1'b1, t ^ 27'h1), ent(1'b1, t ^ 27'h4000000), ent(1'b1, 27'h0));
    exp_q.push_back(mk_exp(K_MISS, '0, 1'b0, 39'h123456780, 7'h11));
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      // keep a hit-able request pending: it must not be taken while parked
      if (c == 0) set_req(7'h33, 1'b1, 1'b1, {th, 12'h000}, ent(1'b1, th), ent(1'b1, th), ent(1'b1, th), ent(1'b1, th));
      checks++; if ({mshr_allocate_valid, in_ready, hit_valid} !== 3'b100) begin errors++; $display("FAIL miss_wait%0d: valid/in_ready/hit got %b required 100", c, {mshr_allocate_valid, in_ready, hit_valid}); end
      checks++; if ({mshr_allocate_paddr, mshr_allocate_robid} !== {exp_q[0].paddr, exp_q[0].robid}) begin errors++; $display("FAIL miss_hold%0d: got %h/%h required %h/%h", c, mshr_allocate_paddr, mshr_allocate_robid, exp_q[0].paddr, exp_q[0].robid); end
    end
    mshr_allocate_ready = 1'b1;
    e = exp_q.pop_front(); exp_miss_cnt++;
    checks++; if ({mshr_allocate_paddr, mshr_allocate_robid} !== {e.paddr, e.robid}) begin errors++; $display("FAIL miss_handshake: got %h/%h required %h/%h", mshr_allocate_paddr, mshr_allocate_robid, e.paddr, e.robid); end
    @(negedge clock); clr_req(); mshr_allocate_ready = 1'b0;
    checks++; if ({mshr_allocate_valid, in_ready, hit_valid} !== 3'b010) begin errors++; $display("FAIL miss_release: valid/in_ready/hit got %b required 010", {mshr_allocate_valid, in_ready, hit_valid}); end
    checks++; if ({perf_miss_cnt, perf_hit_cnt} !== {exp_miss_cnt, exp_hit_cnt}) begin errors++; $display("FAIL miss_cnt: got %0d/%0d required %0d/%0d", perf_miss_cnt, perf_hit_cnt, exp_miss_cnt, exp_hit_cnt); end
  endtask

  task automatic test_replay();
    logic [TAG_W-1:0]   t;
    exp_t               e;
    t = 27'h0042424;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      // k=0: TLB miss; k=1: TLB response not valid
      if (k == 0) set_req(7'h2A, 1'b1, 1'b0, {t, 12'h000}, ent(1'b1, t), ent(1'b1, t), ent(1'b1, t), ent(1'b1, t));
      else        set_req(7'h15, 1'b0, 1'b1, {t, 12'h000}, ent(1'b1, t), ent(1'b1, t), ent(1'b1, t), ent(1'b1, t));
      exp_q.push_back(mk_exp(K_REPLAY, '0, 1'b0, '0, (k == 0) ? 7'h2A : 7'h15));
      @(negedge clock); clr_req();
      checks++; if ({replay_valid, hit_valid, mshr_allocate_valid} !== 3'b100) begin errors++; $display("FAIL replay%0d_pulse: replay/hit/mshr got %b required 100", k, {replay_valid, hit_valid, mshr_allocate_valid}); end
      e = exp_q.pop_front();
      checks++; if (replay_robid !== e.robid) begin errors++; $display("FAIL replay%0d_robid: got %h required %h", k, replay_robid, e.robid); end
      checks++; if ({perf_hit_cnt, perf_miss_cnt} !== {exp_hit_cnt, exp_miss_cnt}) begin errors++; $display("FAIL replay%0d_cnt: got %0d/%0d required %0d/%0d", k, perf_hit_cnt, perf_miss_cnt, exp_hit_cnt, exp_miss_cnt); end
      @(negedge clock);
      checks++; if ({replay_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL replay%0d_width: replay/in_ready got %b required 01", k, {replay_valid, in_ready}); end
    end
  endtask

  task automatic test_flush();
    logic [TAG_W-1:0]   t;
    exp_t               e;
    t = 27'h0123456;
    // flush in the fire cycle drops the request
    @(negedge clock);
    set_req(7'h01, 1'b1, 1'b1, {t, 12'h000}, ent(1'b1, t), ent(1'b0, t), ent(1'b0, t), ent(1'b0, t));
    flush = 1'b1;
    @(negedge clock); flush = 1'b0; clr_req();
    checks++; if ({hit_valid, replay_valid, mshr_allocate_valid} !== 3'b000) begin errors++; $display("FAIL flush_fire_drop: got %b required 000", {hit_valid, replay_valid, mshr_allocate_valid}); end
    checks++; if (perf_hit_cnt !== exp_hit_cnt) begin errors++; $display("FAIL flush_fire_cnt: got %0d required %0d", perf_hit_cnt, exp_hit_cnt); end
    // flush while parked, MSHR not ready
    set_req(7'h22, 1'b1, 1'b1, 39'h0abcde03f, ent(1'b0, '0), ent(1'b0, '0), ent(1'b0, '0), ent(1'b0, '0));
    exp_q.push_back(mk_exp(K_MISS, '0, 1'b0, 39'h0abcde000, 7'h22));
    @(negedge clock); clr_req();
    e = exp_q.pop_front();
    checks++; if ({mshr_allocate_valid, mshr_allocate_paddr, mshr_allocate_robid} !== {1'b1, e.paddr, e.robid}) begin errors++; $display("FAIL flush_park: got %b/%h/%h required 1/%h/%h", mshr_allocate_valid, mshr_allocate_paddr, mshr_allocate_robid, e.paddr, e.robid); end
    flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    checks++; if ({mshr_allocate_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_wait: valid/in_ready got %b required 01", {mshr_allocate_valid, in_ready}); end
    checks++; if (perf_miss_cnt !== exp_miss_cnt) begin errors++; $display("FAIL flush_wait_cnt: got %0d required %0d", perf_miss_cnt, exp_miss_cnt); end
    // flush coincident with the MSHR handshake: handshake still counts
    set_req(7'h44, 1'b1, 1'b1, 39'h555555555, ent(1'b0, '0), ent(1'b0, '0), ent(1'b0, '0), ent(1'b0, '0));
    exp_q.push_back(mk_exp(K_MISS, '0, 1'b0, 39'h555555540, 7'h44));
    @(negedge clock); clr_req();
    e = exp_q.pop_front();
    checks++; if ({mshr_allocate_valid, mshr_allocate_paddr, mshr_allocate_robid} !== {1'b1, e.paddr, e.robid}) begin errors++; $display("FAIL flush_hs_park: got %b/%h/%h required 1/%h/%h", mshr_allocate_valid, mshr_allocate_paddr, mshr_allocate_robid, e.paddr, e.robid); end
    flush = 1'b1; mshr_allocate_ready = 1'b1; exp_miss_cnt++;
    @(negedge clock); flush = 1'b0; mshr_allocate_ready = 1'b0;
    checks++; if ({mshr_allocate_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_hs_state: valid/in_ready got %b required 01", {mshr_allocate_valid, in_ready}); end
    checks++; if (perf_miss_cnt !== exp_miss_cnt) begin errors++; $display("FAIL flush_hs_cnt: got %0d required %0d", perf_miss_cnt, exp_miss_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [TAG_W-1:0]   t;
    logic [PADDR_W-1:0] pa;
    logic [ENT_W-1:0]   ents[WAY_NUM];
    logic [WAY_NUM-1:0] onehot[3];
    int                 way_idx[3];
    exp_t               e;
    t = 27'h0000abc;
    way_idx[0] = 0; way_idx[1] = 1; way_idx[2] = 3;
    onehot[0] = 4'b0001; onehot[1] = 4'b0010; onehot[2] = 4'b1000;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clock);
      if (i > 0) begin
        checks++; if (hit_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_pulse: got %b required 1", i - 1, hit_valid); end
        e = exp_q.pop_front();
        checks++; if ({hit_way, hit_paddr, hit_robid} !== {e.way, e.paddr, e.robid}) begin errors++; $display("FAIL b2b%0d_info: got %b/%h/%h required %b/%h/%h", i - 1, hit_way, hit_paddr, hit_robid, e.way, e.paddr, e.robid); end
        checks++; if (perf_hit_cnt !== exp_hit_cnt) begin errors++; $display("FAIL b2b%0d_cnt: got %0d required %0d", i - 1, perf_hit_cnt, exp_hit_cnt); end
      end
      if (i < 3) begin
        pa = {t, 12'h000} + PADDR_W'(i * 64);
        for (int w = 0; w < WAY_NUM; w++) ents[w] = ent(w == way_idx[i], t);
        set_req(ROBID_W'(i + 1), 1'b1, 1'b1, pa, ents[0], ents[1], ents[2], ents[3]);
        exp_q.push_back(mk_exp(K_HIT, onehot[i], 1'b0, pa, ROBID_W'(i + 1))); exp_hit_cnt++;
      end else begin
        clr_req();
      end
    end
    @(negedge clock);
    checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b required 0", hit_valid); end
  endtask

  task automatic test_async_reset();
    logic [TAG_W-1:0] t;
    exp_t             e;
    @(negedge clock);
    set_req(7'h5e, 1'b1, 1'b1, 39'h700001fff, ent(1'b0, '0), ent(1'b0, '0), ent(1'b0, '0), ent(1'b0, '0));
    exp_q.push_back(mk_exp(K_MISS, '0, 1'b0, 39'h700001fc0, 7'h5e));
    @(negedge clock); clr_req();
    e = exp_q.pop_front();
    checks++; if ({mshr_allocate_valid, mshr_allocate_paddr} !== {1'b1, e.paddr}) begin errors++; $display("FAIL areset_park: got %b/%h required 1/%h", mshr_allocate_valid, mshr_allocate_paddr, e.paddr); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({hit_valid, replay_valid, mshr_allocate_valid, multihit, in_ready} !== 5'b00001) begin errors++; $display("FAIL areset_ctrl: got %b required 00001", {hit_valid, replay_valid, mshr_allocate_valid, multihit, in_ready}); end
    checks++; if ({perf_hit_cnt, perf_miss_cnt, mshr_allocate_paddr, hit_paddr} !== '0) begin errors++; $display("FAIL areset_data: got %0d/%0d/%h/%h required all 0", perf_hit_cnt, perf_miss_cnt, mshr_allocate_paddr, hit_paddr); end
    exp_hit_cnt = '0; exp_miss_cnt = '0;
    @(negedge clock); reset_n = 1'b1;
    t = 27'h1234567;
    @(negedge clock);
    set_req(7'h7f, 1'b1, 1'b1, {t, 12'hfff}, ent(1'b0, t), ent(1'b0, t), ent(1'b0, t), ent(1'b1, t));
    exp_q.push_back(mk_exp(K_HIT, 4'b1000, 1'b0, {t, 12'hfff}, 7'h7f)); exp_hit_cnt++;
    @(negedge clock); clr_req();
    e = exp_q.pop_front();
    checks++; if ({hit_valid, hit_way, hit_robid} !== {1'b1, e.way, e.robid}) begin errors++; $display("FAIL areset_recover: got %b/%b/%h required 1/%b/%h", hit_valid, hit_way, hit_robid, e.way, e.robid); end
    checks++; if (perf_hit_cnt !== exp_hit_cnt) begin errors++; $display("FAIL areset_recover_cnt: got %0d required %0d", perf_hit_cnt, exp_hit_cnt); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_multihit();
    test_miss();
    test_replay();
    test_flush();
    test_back_to_back();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
